wb_scalar_arbiter: RTL and testbench
====================================

# wb_scalar_arbiter

- Downstream writeback stage for the scalar execution units (CSR unit, ALU, MUL, SFU).
- Each source holds its result in a one-entry buffer. A round-robin arbiter moves one buffered result per cycle into a registered output slot, which drives the scalar register-file write port and the scoreboard release.
- Every result is delivered, including those with write disabled, so the scoreboard always sees completion.

## Interface
Parameters:
- NUM_SRC, 4, number of writeback sources; source 0 is the CSR unit.
- DATA_W, `XLEN, writeback data width.
- IDX_W, `REGIDX_WIDTH+`REGEXT_WIDTH, destination register index width.
- WID_W, `DEPTH_WARP, warp id width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- src_valid_i  in  NUM_SRC  per-source result valid.
- src_ready_o  out  NUM_SRC  per-source ready.
- src_wxd_i  in  NUM_SRC  per-source scalar write enable.
- src_rd_i  in  NUM_SRC*DATA_W  per-source data; source i occupies bits [(i+1)*DATA_W-1 -: DATA_W].
- src_reg_idxw_i  in  NUM_SRC*IDX_W  per-source destination index; packed the same way.
- src_warp_id_i  in  NUM_SRC*WID_W  per-source warp id; packed the same way.
- out_valid_o  out  1  writeback valid.
- out_ready_i  in  1  register file / scoreboard ready.
- out_wxd_o  out  1  write enable after x0 suppression.
- out_rd_o  out  DATA_W  writeback data.
- out_reg_idxw_o  out  IDX_W  destination index.
- out_warp_id_o  out  WID_W  warp id.
- out_src_o  out  $clog2(NUM_SRC)  index of the source that produced the current output.

## Operation
**Source buffers**
- One buffer per source: buf_v[i] plus payload.
- src fire[i] = src_valid_i[i] & src_ready_o[i]; on fire, the payload is loaded into buffer i.
- slot_free = ~out_valid_o | out_ready_i.
- src_ready_o[i] = ~buf_v[i] | (grant[i] & slot_free). A source can therefore refill its buffer in the same cycle the buffer drains.

**Arbitration**
- Combinational round-robin over buf_v, searching from ptr upward with wrap-around.
- A grant is issued only when slot_free = 1.
- On grant of source g: ptr <= (g == NUM_SRC-1) ? 0 : g+1. ptr holds when there is no grant.

**Output slot**
- On grant, the slot loads the granted payload and out_src_o = g, and out_valid_o <= 1.
- If there is no grant and out_ready_i = 1, out_valid_o <= 0.
- While out_valid_o = 1 and out_ready_i = 0, all output fields hold stable.

**x0 suppression**
- out_wxd_o = buffered wxd & (reg_idxw != 0). The rule is applied at slot load.
- The entry is still delivered with out_valid_o = 1.

**Ordering**
- Per source, order is preserved, since each source has a single buffer.
- Across sources, order is round-robin only.

**Reset**
- buf_v = 0, ptr = 0, out_valid_o = 0.
- out_wxd_o = 0, out_rd_o = 0, out_reg_idxw_o = 0, out_warp_id_o = 0, out_src_o = 0.
- src_ready_o is all-ones in the first cycle after reset deasserts.
- Reset asserted mid-operation discards all buffered and slotted results without emitting them.

## Timing
- Latency is 2 cycles minimum: a fire at edge t makes buf_v = 1 during t+1; the grant occurs in t+1, and out_valid_o = 1 during t+2.
- Aggregate throughput is one result per cycle under continuous out_ready_i.
- A single active source also sustains one result per cycle.
- Under full backpressure (out_ready_i = 0), up to NUM_SRC buffered results plus 1 slotted result are held. src_ready_o[i] = 0 exactly when buf_v[i] = 1.
- With all buffers full and out_ready_i = 1, grants rotate 0,1,2,3,0… starting from ptr.
- A simultaneous src fire and grant on the same source replaces the buffer contents with no bubble and no loss.
- No combinational path from out_ready_i to out_valid_o. The only combinational path from out_ready_i is to src_ready_o.

## Structure
- Width macros come from the shared define.v (`XLEN, `REGIDX_WIDTH, `REGEXT_WIDTH, `DEPTH_WARP). No new global constants are needed.
- Sub-module wb_rr_arbiter: a parameterized N-way round-robin arbiter.
  - Inputs: req, en, clk, rst_n.
  - Outputs: one-hot grant and its encoded index.
  - It owns ptr.
- The top level holds the buffers, the output slot and x0 suppression.

## Test plan
- **Reset:** hold rst_n = 0 for 3 cycles with src_valid_i = 4'hF → out_valid_o = 0, all outputs 0; src_ready_o = 4'hF in the cycle after release.
- **Single source:** source 0 (CSR) streams 8 results, wxd = 1, reg_idxw 1..8, warp 3, with out_ready_i = 1 → out_valid_o from cycle 2 onward, 1 per cycle, idx 1..8 in order, out_src_o = 0.
- **Round-robin:** fill all 4 buffers with out_ready_i = 0, then release → delivery order 0,1,2,3. Refill and release again → order continues from the updated ptr, with no source granted twice before each other requester is served once.
- **x0 suppression:** source 2 sends wxd = 1, reg_idxw = 0, data 32'hDEADBEEF → out_valid_o = 1, out_wxd_o = 0, out_src_o = 2.
- **Backpressure:** toggle out_ready_i randomly for 1000 cycles with random src_valid_i → no loss, no duplication, per-source order preserved, outputs stable while stalled.
- **Reset mid-operation:** assert rst_n = 0 with 3 buffers full → after release, nothing is emitted and ptr restarts at 0.

Source files
------------

// File: rtl/wb_scalar_arbiter_pkg.sv
// Shared widths and helpers for the scalar writeback arbiter.
package wb_scalar_arbiter_pkg;

    localparam int WB_XLEN     = 32;
    localparam int WB_REGIDX_W = 5;
    localparam int WB_REGEXT_W = 3;
    localparam int WB_WID_W    = 3;

    localparam int WB_IDX_W   = WB_REGIDX_W + WB_REGEXT_W;
    localparam int WB_NUM_SRC = 4;

    // A write to x0 is architecturally a no-op, but the result still completes.
    function automatic logic wb_x0_wxd(input logic wxd, input logic idx_nonzero);
        return wxd & idx_nonzero;
    endfunction

endpackage

// File: rtl/wb_scalar_arbiter_rr.sv
// N-way round-robin arbiter: searches req_i from ptr upward with wrap-around.
// The pointer advances past the granted requester and holds when nothing is granted.
module wb_rr_arbiter
    import wb_scalar_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    localparam logic [IW:0]   N_L    = (IW+1)'(N);
    localparam logic [IW-1:0] LAST_L = IW'(N - 1);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW:0]   sum_s;
    logic [IW-1:0] cand_s;
    logic          found_s;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found_s     = 1'b0;
        sum_s       = '0;
        cand_s      = '0;
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum_s >= N_L) begin
                cand_s = IW'(sum_s - N_L);
            end else begin
                cand_s = IW'(sum_s);
            end
            if (en_i && !found_s && req_i[cand_s]) begin
                found_s     = 1'b1;
                grant_o     = '0;
                grant_o[cand_s] = 1'b1;
                grant_idx_o = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next pointer: one past the winner, wrapping at the last requester.
    always_comb begin
        ptr_d = ptr_q;
        if (found_s) begin
            if (grant_idx_o == LAST_L) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_o + IW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_scalar_arbiter.sv
// Scalar writeback stage: one-entry buffer per source, round-robin selection
// into a registered output slot, x0 write suppression applied at slot load.
module wb_scalar_arbiter
    import wb_scalar_arbiter_pkg::*;
#(
    parameter int NUM_SRC = WB_NUM_SRC,
    parameter int DATA_W  = WB_XLEN,
    parameter int IDX_W   = WB_IDX_W,
    parameter int WID_W   = WB_WID_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC-1:0]           src_valid_i,
    output logic [NUM_SRC-1:0]           src_ready_o,
    input  logic [NUM_SRC-1:0]           src_wxd_i,
    input  logic [NUM_SRC*DATA_W-1:0]    src_rd_i,
    input  logic [NUM_SRC*IDX_W-1:0]     src_reg_idxw_i,
    input  logic [NUM_SRC*WID_W-1:0]     src_warp_id_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         out_wxd_o,
    output logic [DATA_W-1:0]            out_rd_o,
    output logic [IDX_W-1:0]             out_reg_idxw_o,
    output logic [WID_W-1:0]             out_warp_id_o,
    output logic [$clog2(NUM_SRC)-1:0]   out_src_o
);

    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] buf_v_q;
    logic [NUM_SRC-1:0] buf_wxd_q;
    logic [DATA_W-1:0]  buf_rd_q  [NUM_SRC];
    logic [IDX_W-1:0]   buf_idx_q [NUM_SRC];
    logic [WID_W-1:0]   buf_wid_q [NUM_SRC];

    logic               out_valid_q;
    logic               out_wxd_q;
    logic [DATA_W-1:0]  out_rd_q;
    logic [IDX_W-1:0]   out_idx_q;
    logic [WID_W-1:0]   out_wid_q;
    logic [SRC_W-1:0]   out_src_q;

    logic               slot_free_s;
    logic               any_grant_s;
    logic [NUM_SRC-1:0] grant_s;
    logic [NUM_SRC-1:0] fire_s;
    logic [SRC_W-1:0]   grant_idx_s;

    assign slot_free_s = ~out_valid_q | out_ready_i;
    assign any_grant_s = |grant_s;
    // Grants are already gated by slot_free, so a draining buffer accepts a refill.
    assign src_ready_o = ~buf_v_q | grant_s;
    assign fire_s      = src_valid_i & src_ready_o;

    wb_rr_arbiter #(
        .N  (NUM_SRC),
        .IW (SRC_W)
    ) u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (buf_v_q),
        .en_i        (slot_free_s),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s)
    );

    // Per-source buffers: load on fire, otherwise clear when granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_v_q   <= '0;
            buf_wxd_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                buf_rd_q[i]  <= '0;
                buf_idx_q[i] <= '0;
                buf_wid_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (fire_s[i]) begin
                    buf_v_q[i]   <= 1'b1;
                    buf_wxd_q[i] <= src_wxd_i[i];
                    buf_rd_q[i]  <= src_rd_i[i*DATA_W +: DATA_W];
                    buf_idx_q[i] <= src_reg_idxw_i[i*IDX_W +: IDX_W];
                    buf_wid_q[i] <= src_warp_id_i[i*WID_W +: WID_W];
                end else if (grant_s[i]) begin
                    buf_v_q[i] <= 1'b0;
                end else begin
                    buf_v_q[i] <= buf_v_q[i];
                end
            end
        end
    end

    // Output slot: load the winner, empty when consumed with no new winner, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_wxd_q   <= 1'b0;
            out_rd_q    <= '0;
            out_idx_q   <= '0;
            out_wid_q   <= '0;
            out_src_q   <= '0;
        end else if (any_grant_s) begin
            out_valid_q <= 1'b1;
            out_wxd_q   <= wb_x0_wxd(buf_wxd_q[grant_idx_s], |buf_idx_q[grant_idx_s]);
            out_rd_q    <= buf_rd_q[grant_idx_s];
            out_idx_q   <= buf_idx_q[grant_idx_s];
            out_wid_q   <= buf_wid_q[grant_idx_s];
            out_src_q   <= grant_idx_s;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_wxd_o      = out_wxd_q;
    assign out_rd_o       = out_rd_q;
    assign out_reg_idxw_o = out_idx_q;
    assign out_warp_id_o  = out_wid_q;
    assign out_src_o      = out_src_q;

endmodule

// File: tb/tb_wb_scalar_arbiter.sv
// Directed and random bench for wb_scalar_arbiter with a queue-based reference model.
module tb_wb_scalar_arbiter;
    import wb_scalar_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = WB_XLEN;
    localparam int IW = WB_IDX_W;
    localparam int WW = WB_WID_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N-1:0]      src_valid_i, src_ready_o, src_wxd_i;
    logic [N*DW-1:0]   src_rd_i;
    logic [N*IW-1:0]   src_reg_idxw_i;
    logic [N*WW-1:0]   src_warp_id_i;
    logic              out_valid_o, out_ready_i, out_wxd_o;
    logic [DW-1:0]     out_rd_o;
    logic [IW-1:0]     out_reg_idxw_o;
    logic [WW-1:0]     out_warp_id_o;
    logic [1:0]        out_src_o;

    wb_scalar_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_wxd_i(src_wxd_i),
        .src_rd_i(src_rd_i), .src_reg_idxw_i(src_reg_idxw_i), .src_warp_id_i(src_warp_id_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_wxd_o(out_wxd_o),
        .out_rd_o(out_rd_o), .out_reg_idxw_o(out_reg_idxw_o), .out_warp_id_o(out_warp_id_o),
        .out_src_o(out_src_o)
    );

    // Stimulus values for the next cycle
    logic [DW-1:0] d_rd  [N];
    logic [IW-1:0] d_idx [N];
    logic [WW-1:0] d_wid [N];

    // Reference model: pending result per source, one output slot, rotating pointer
    int            m_has [N];
    logic          m_wxd [N];
    logic [DW-1:0] m_rd  [N];
    logic [IW-1:0] m_idx [N];
    logic [WW-1:0] m_wid [N];
    int            m_ptr;
    logic [N-1:0]  m_fired;
    logic          s_v, s_wxd;
    logic [DW-1:0] s_rd;
    logic [IW-1:0] s_idx;
    logic [WW-1:0] s_wid;
    int            s_src;

    // Per-source send-order scoreboard
    logic [DW-1:0] sb_mem [N][2048];
    int            sb_wr [N];
    int            sb_rd [N];
    int            obs_order[$];
    int            obs_idx[$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input string ph);
        int g;
        int c;
        logic sf;
        logic [N-1:0] rdy_exp;
        for (int i = 0; i < N; i++) begin
            src_rd_i[i*DW +: DW]       = d_rd[i];
            src_reg_idxw_i[i*IW +: IW] = d_idx[i];
            src_warp_id_i[i*WW +: WW]  = d_wid[i];
        end
        #2;
        m_fired = '0;
        if (rst_n) begin
            sf = !s_v || out_ready_i;
            g  = -1;
            if (sf) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (g < 0 && m_has[c] != 0) g = c;
                end
            end
            for (int i = 0; i < N; i++) rdy_exp[i] = (m_has[i] == 0) || (g == i);
            chk({ph, ".src_ready"}, 64'(src_ready_o), 64'(rdy_exp));
            if (s_v && out_ready_i) begin
                obs_order.push_back(int'(out_src_o));
                obs_idx.push_back(int'(out_reg_idxw_o));
                if (sb_rd[s_src] < sb_wr[s_src]) begin
                    chk({ph, ".sb_data"}, 64'(out_rd_o), 64'(sb_mem[s_src][sb_rd[s_src]]));
                    sb_rd[s_src]++;
                end else begin
                    chk({ph, ".sb_unexpected"}, 64'(1), 64'(0));
                end
            end
            if (g >= 0) begin
                s_v = 1'b1; s_src = g; s_rd = m_rd[g]; s_idx = m_idx[g]; s_wid = m_wid[g];
                s_wxd = m_wxd[g] && (m_idx[g] != '0);
                m_ptr = (g + 1) % N;
            end else if (out_ready_i) begin
                s_v = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (src_valid_i[i] && rdy_exp[i]) begin
                    m_has[i] = 1; m_wxd[i] = src_wxd_i[i];
                    m_rd[i] = d_rd[i]; m_idx[i] = d_idx[i]; m_wid[i] = d_wid[i];
                    m_fired[i] = 1'b1;
                    sb_mem[i][sb_wr[i]] = d_rd[i];
                    sb_wr[i]++;
                end else if (g == i) begin
                    m_has[i] = 0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                m_has[i] = 0; sb_rd[i] = sb_wr[i];
            end
            m_ptr = 0; s_v = 1'b0; s_wxd = 1'b0; s_rd = '0; s_idx = '0; s_wid = '0; s_src = 0;
        end
        @(posedge clk);
        #1;
        chk({ph, ".out_valid"}, 64'(out_valid_o), 64'(s_v));
        chk({ph, ".out_wxd"},   64'(out_wxd_o),   64'(s_wxd));
        chk({ph, ".out_rd"},    64'(out_rd_o),    64'(s_rd));
        chk({ph, ".out_idx"},   64'(out_reg_idxw_o), 64'(s_idx));
        chk({ph, ".out_wid"},   64'(out_warp_id_o),  64'(s_wid));
        chk({ph, ".out_src"},   64'(out_src_o),   64'(s_src));
    endtask

    task automatic idle(input string ph, input int n, input logic rdy);
        src_valid_i = '0;
        out_ready_i = rdy;
        for (int i = 0; i < n; i++) step(ph);
    endtask

    initial begin
        int cnt;
        int stp;
        int exp_rr1[4];
        int exp_rr2[3];
        exp_rr1 = '{0, 1, 2, 3};
        exp_rr2 = '{3, 1, 2};
        for (int i = 0; i < N; i++) begin
            d_rd[i] = '0; d_idx[i] = '0; d_wid[i] = '0;
            sb_wr[i] = 0; sb_rd[i] = 0; m_has[i] = 0;
        end
        s_v = 1'b0; s_src = 0; m_ptr = 0;

        // Reset held with all sources requesting
        rst_n = 1'b0; src_valid_i = 4'hF; src_wxd_i = 4'hF; out_ready_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            d_rd[i] = 32'h1000_0000 + 32'(i); d_idx[i] = IW'(i + 1); d_wid[i] = WW'(i);
        end
        for (int i = 0; i < 3; i++) step("reset");
        rst_n = 1'b1;
        obs_order.delete();
        step("reset_release");
        chk("reset.ready_after_release_fired", 64'(m_fired), 64'(4'hF));

        // Round-robin: all four buffered under backpressure, then released
        idle("rr1_stall", 2, 1'b0);
        idle("rr1_drain", 6, 1'b1);
        chk("rr1.count", 64'(obs_order.size()), 64'(4));
        for (int i = 0; i < 4 && i < obs_order.size(); i++)
            chk("rr1.order", 64'(obs_order[i]), 64'(exp_rr1[i]));

        // Move the pointer to 3 with one result from source 2, then refill 1..3
        src_valid_i = 4'b0100; out_ready_i = 1'b1; d_rd[2] = 32'h2222_0001;
        step("rr2_pre");
        idle("rr2_pre", 3, 1'b1);
        obs_order.delete();
        src_valid_i = 4'b1110; out_ready_i = 1'b0;
        step("rr2_fill");
        idle("rr2_stall", 2, 1'b0);
        idle("rr2_drain", 6, 1'b1);
        chk("rr2.count", 64'(obs_order.size()), 64'(3));
        for (int i = 0; i < 3 && i < obs_order.size(); i++)
            chk("rr2.order", 64'(obs_order[i]), 64'(exp_rr2[i]));

        // Single source streaming 8 results, one per cycle
        obs_order.delete(); obs_idx.delete();
        cnt = 0; stp = 0; out_ready_i = 1'b1; src_wxd_i = 4'b0001; d_wid[0] = WW'(3);
        while (cnt < 8 && stp < 20) begin
            src_valid_i = 4'b0001; d_idx[0] = IW'(cnt + 1); d_rd[0] = 32'hC500_0000 + 32'(cnt);
            step("single");
            stp++;
            if (m_fired[0]) cnt++;
        end
        chk("single.cycles_for_8", 64'(stp), 64'(8));
        idle("single_drain", 4, 1'b1);
        chk("single.count", 64'(obs_idx.size()), 64'(8));
        for (int i = 0; i < 8 && i < obs_idx.size(); i++) begin
            chk("single.idx_order", 64'(obs_idx[i]), 64'(i + 1));
            chk("single.src", 64'(obs_order[i]), 64'(0));
        end

        // x0 suppression on source 2
        src_valid_i = 4'b0100; src_wxd_i = 4'b0100; out_ready_i = 1'b1;
        d_rd[2] = 32'hDEAD_BEEF; d_idx[2] = '0; d_wid[2] = WW'(1);
        step("x0_send");
        idle("x0_grant", 1, 1'b1);
        chk("x0.valid", 64'(out_valid_o), 64'(1));
        chk("x0.wxd",   64'(out_wxd_o),   64'(0));
        chk("x0.src",   64'(out_src_o),   64'(2));
        chk("x0.data",  64'(out_rd_o),    64'(32'hDEAD_BEEF));
        idle("x0_drain", 2, 1'b1);

        // Random traffic with random backpressure
        for (int t = 0; t < 1000; t++) begin
            src_valid_i = N'($urandom);
            src_wxd_i   = N'($urandom);
            out_ready_i = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) begin
                d_rd[i]  = $urandom;
                d_idx[i] = ($urandom_range(0, 3) == 0) ? '0 : IW'($urandom);
                d_wid[i] = WW'($urandom);
            end
            step("random");
        end
        idle("random_drain", 10, 1'b1);
        for (int i = 0; i < N; i++)
            chk("random.all_delivered", 64'(sb_wr[i] - sb_rd[i]), 64'(0));

        // Reset while three buffers and the slot are occupied
        src_valid_i = 4'b1110; out_ready_i = 1'b0;
        step("midrst_fill");
        idle("midrst_fill", 1, 1'b0);
        src_valid_i = 4'b1110;
        step("midrst_fill");
        rst_n = 1'b0;
        idle("midrst_reset", 2, 1'b0);
        rst_n = 1'b1;
        obs_order.delete();
        idle("midrst_after", 4, 1'b1);
        chk("midrst.nothing_emitted", 64'(obs_order.size()), 64'(0));
        src_valid_i = 4'b1010;
        step("midrst_ptr");
        idle("midrst_ptr", 4, 1'b1);
        chk("midrst.count", 64'(obs_order.size()), 64'(2));
        if (obs_order.size() > 0) chk("midrst.ptr_restart", 64'(obs_order[0]), 64'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
